// File: rtl/result_shift_out_if.sv
// Handshake bundle for the result shift-out block: parallel load side and serial side.
interface result_shift_out_if #(
    parameter int unsigned WIDTH = 62
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;

    // Test harness side: supplies words, consumes serial bits
    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_data, ser_last
    );

    // Transmitter side
    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_data, ser_last
    );
endinterface

// File: rtl/result_shift_out.sv
// Parallel-in/serial-out transmitter for compressor result words with
// valid/ready on both sides and a saturating completed-word counter.
module result_shift_out #(
    parameter int unsigned WIDTH     = 62,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    result_shift_out_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);
    localparam int unsigned      BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX  = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WORDS_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_last_q, ser_last_d;
    logic               busy_q, busy_d;
    logic               load_ready_q, load_ready_d;

    // Next state, datapath update and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        words_d   = words_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    shreg_d   = bus.load_data;
                    bit_cnt_d = LAST_IDX;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // ser_valid is high throughout SHIFT, so ser_ready alone marks a beat
                if (bus.ser_ready) begin
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    if (bit_cnt_q == '0) begin
                        state_d = ST_IDLE;
                        if (words_q != WORDS_MAX) begin
                            words_d = words_q + CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ser_valid_d  = (state_d == ST_SHIFT);
        busy_d       = (state_d == ST_SHIFT);
        load_ready_d = (state_d == ST_IDLE);
        ser_last_d   = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
        ser_data_d   = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            words_q      <= '0;
            ser_valid_q  <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            words_q      <= words_d;
            ser_valid_q  <= ser_valid_d;
            ser_data_q   <= ser_data_d;
            ser_last_q   <= ser_last_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_data   = ser_data_q;
    assign bus.ser_last   = ser_last_q;
    assign busy           = busy_q;
    assign words_sent     = words_q;
endmodule
